// File: rtl/camera_timing_probe.sv
// Measures OV5640 byte-stream geometry (row length, rows, bytes, fps, bytes/s,
// per-frame min/max row) with its own timebase and a frame-geometry stability flag.
module camera_timing_probe #(
  parameter int unsigned REF_CLK  = 307_200_000,
  parameter int unsigned CNT_W    = 16,
  parameter int unsigned STABLE_N = 4
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        valid_byte_in,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic [2:0]  mode_in,
  input  logic        clear_in,
  output logic [31:0] display_out,
  output logic        stable_out,
  output logic        one_hz_out
);

  localparam int TB_W = $clog2(REF_CLK + 1);
  localparam int M_W  = $clog2(STABLE_N + 1);

  typedef struct packed {
    logic             hs_prev;
    logic             vs_prev;
    logic [CNT_W-1:0] row_cnt;
    logic [CNT_W-1:0] rowlen;
    logic [CNT_W-1:0] rows_cnt;
    logic [CNT_W-1:0] cur_min;
    logic [CNT_W-1:0] cur_max;
    logic [CNT_W-1:0] rows;
    logic [CNT_W-1:0] rowmin;
    logic [CNT_W-1:0] rowmax;
    logic [CNT_W-1:0] frame_cnt;
    logic [CNT_W-1:0] fps;
    logic [31:0]      byte_cnt;
    logic [31:0]      fbytes;
    logic [31:0]      bps_cnt;
    logic [31:0]      bps;
    logic [M_W-1:0]   match_cnt;
    logic             stable;
    logic             one_hz;
    logic [TB_W-1:0]  tb_cnt;
    logic [31:0]      display;
  } probe_state_t;

  probe_state_t st_q, st_d;
  logic         row_end;
  logic         frame_end;

  function automatic logic [CNT_W-1:0] sat_inc_c(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  function automatic logic [31:0] sat_inc_w(input logic [31:0] v);
    return (&v) ? v : v + 32'd1;
  endfunction

  // Sync levels only mean something when they accompany an accepted byte.
  assign row_end   = valid_byte_in & st_q.hs_prev & ~hsync_in;
  assign frame_end = valid_byte_in & st_q.vs_prev & ~vsync_in;

  always_comb begin
    st_d = st_q;

    st_d.tb_cnt = st_q.one_hz ? TB_W'(1) : st_q.tb_cnt + TB_W'(1);
    st_d.one_hz = (st_d.tb_cnt == TB_W'(REF_CLK));

    if (valid_byte_in) begin
      st_d.hs_prev  = hsync_in;
      st_d.vs_prev  = vsync_in;
      st_d.byte_cnt = sat_inc_w(st_q.byte_cnt);
      if (row_end) begin
        st_d.rowlen   = st_q.row_cnt;
        st_d.row_cnt  = '0;
        st_d.rows_cnt = sat_inc_c(st_q.rows_cnt);
        st_d.cur_min  = (st_q.row_cnt < st_q.cur_min) ? st_q.row_cnt : st_q.cur_min;
        st_d.cur_max  = (st_q.row_cnt > st_q.cur_max) ? st_q.row_cnt : st_q.cur_max;
      end else begin
        st_d.row_cnt  = sat_inc_c(st_q.row_cnt);
      end
      // The row closing on this byte is already folded into the values latched here.
      if (frame_end) begin
        if (st_q.rows == st_d.rows_cnt && st_q.fbytes == st_q.byte_cnt &&
            st_d.cur_min == st_d.cur_max) begin
          st_d.match_cnt = (st_q.match_cnt == M_W'(STABLE_N)) ? st_q.match_cnt
                                                             : st_q.match_cnt + M_W'(1);
        end else begin
          st_d.match_cnt = '0;
        end
        st_d.rows     = st_d.rows_cnt;
        st_d.fbytes   = st_q.byte_cnt;
        st_d.rowmin   = st_d.cur_min;
        st_d.rowmax   = st_d.cur_max;
        st_d.rows_cnt = '0;
        st_d.byte_cnt = '0;
        st_d.cur_min  = '1;
        st_d.cur_max  = '0;
      end
    end
    st_d.stable = (st_d.match_cnt == M_W'(STABLE_N));

    if (st_q.one_hz) begin
      st_d.fps       = st_q.frame_cnt;
      st_d.bps       = st_q.bps_cnt;
      st_d.frame_cnt = frame_end ? CNT_W'(1) : '0;
      st_d.bps_cnt   = valid_byte_in ? 32'd1 : 32'd0;
    end else begin
      if (frame_end)     st_d.frame_cnt = sat_inc_c(st_q.frame_cnt);
      if (valid_byte_in) st_d.bps_cnt   = sat_inc_w(st_q.bps_cnt);
    end

    case (mode_in)
      3'd0:    st_d.display = {16'(st_q.rows), 16'(st_q.rowlen)};
      3'd1:    st_d.display = st_q.fbytes;
      3'd2:    st_d.display = {16'(st_q.fps), 16'(st_q.rowlen)};
      3'd3:    st_d.display = {16'(st_q.rowmax), 16'(st_q.rowmin)};
      3'd4:    st_d.display = st_q.bps;
      3'd5:    st_d.display = {16'(st_q.match_cnt), 15'b0, st_q.stable};
      default: st_d.display = 32'h0;
    endcase

    if (clear_in) begin
      st_d        = '0;
      st_d.tb_cnt = TB_W'(1);
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) st_q <= '0;
    else           st_q <= st_d;
  end

  assign display_out = st_q.display;
  assign stable_out  = st_q.stable;
  assign one_hz_out  = st_q.one_hz;

endmodule

// File: tb/tb_camera_timing_probe.sv
// Bench for camera_timing_probe: directed frame scenarios plus randomized frames,
// checked against a frame-level reference model with assertions.
module tb_camera_timing_probe;

  localparam int     REF  = 100;
  localparam int     SN   = 4;
  localparam longint CMAX = 65535;
  localparam longint BMAX = 64'h0000_0000_FFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid = 1'b0;
  logic        hs = 1'b0;
  logic        vs = 1'b0;
  logic        clr = 1'b0;
  logic [2:0]  mode = 3'd0;
  logic [31:0] display;
  logic        stable;
  logic        one_hz;

  always #5 clk = ~clk;

  camera_timing_probe #(.REF_CLK(REF), .CNT_W(16), .STABLE_N(SN)) dut (
    .clk_in(clk), .rst_n_in(rst_n), .valid_byte_in(valid), .hsync_in(hs),
    .vsync_in(vs), .mode_in(mode), .clear_in(clr), .display_out(display),
    .stable_out(stable), .one_hz_out(one_hz)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: frames as lists of row lengths, windows as plain cycle arithmetic.
  int          c;
  bit          m_hs, m_vs, floor_zero;
  longint      row_bytes, frame_bytes;
  int          row_q[$];
  longint      m_rowlen, m_rows, m_fbytes, m_rowmin, m_rowmax;
  int          m_match;
  bit          m_stable;
  longint      win_frames, win_bytes, m_fps, m_bps;
  logic [31:0] exp_disp;
  bit          exp_hz;
  int          fr_q[$];

  function automatic longint sat(input longint v, input longint mx);
    return (v > mx) ? mx : v;
  endfunction

  function automatic logic [31:0] disp_of(input logic [2:0] md);
    case (md)
      3'd0:    return {m_rows[15:0], m_rowlen[15:0]};
      3'd1:    return m_fbytes[31:0];
      3'd2:    return {m_fps[15:0], m_rowlen[15:0]};
      3'd3:    return {m_rowmax[15:0], m_rowmin[15:0]};
      3'd4:    return m_bps[31:0];
      3'd5:    return {m_match[15:0], 15'b0, m_stable};
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_reset(input bit by_clear);
    c = by_clear ? 1 : 0;
    m_hs = 0; m_vs = 0; floor_zero = 1;
    row_bytes = 0; frame_bytes = 0; row_q.delete();
    m_rowlen = 0; m_rows = 0; m_fbytes = 0; m_rowmin = 0; m_rowmax = 0;
    m_match = 0; m_stable = 0;
    win_frames = 0; win_bytes = 0; m_fps = 0; m_bps = 0;
    exp_disp = 32'h0; exp_hz = 0;
  endtask

  task automatic model_step(input bit v, input bit h, input bit s, input bit cl);
    logic [31:0] d;
    bit          hz_old, re, fe;
    longint      mn, mx, nrows;
    d = disp_of(mode);
    if (cl) begin
      model_reset(1);
      return;
    end
    exp_disp = d;
    hz_old = (c > 0) && (c % REF == 0);
    c++;
    exp_hz = (c % REF == 0);
    re = v && m_hs && !h;
    fe = v && m_vs && !s;
    if (v) begin m_hs = h; m_vs = s; end
    if (re) begin
      m_rowlen = row_bytes;
      row_q.push_back(int'(row_bytes));
      row_bytes = 0;
    end else if (v) begin
      row_bytes = sat(row_bytes + 1, CMAX);
    end
    if (fe) begin
      nrows = sat(row_q.size(), CMAX);
      mn = floor_zero ? 0 : CMAX;
      mx = 0;
      foreach (row_q[i]) begin
        if (row_q[i] < mn) mn = row_q[i];
        if (row_q[i] > mx) mx = row_q[i];
      end
      if (nrows == m_rows && frame_bytes == m_fbytes && mn == mx)
        m_match = (m_match < SN) ? m_match + 1 : SN;
      else
        m_match = 0;
      m_rows = nrows; m_fbytes = frame_bytes; m_rowmin = mn; m_rowmax = mx;
      row_q.delete(); frame_bytes = 0; floor_zero = 0;
    end else if (v) begin
      frame_bytes = sat(frame_bytes + 1, BMAX);
    end
    m_stable = (m_match == SN);
    if (hz_old) begin
      m_fps = win_frames; m_bps = win_bytes;
      win_frames = fe ? 1 : 0;
      win_bytes  = v ? 1 : 0;
    end else begin
      if (fe) win_frames = sat(win_frames + 1, CMAX);
      if (v)  win_bytes  = sat(win_bytes + 1, BMAX);
    end
  endtask

  task automatic step(input bit v, input bit h, input bit s, input bit cl);
    valid = v; hs = h; vs = s; clr = cl;
    @(posedge clk);
    model_step(v, h, s, cl);
    #1;
  endtask

  task automatic check(input string tag);
    n_checks++;
    assert (display === exp_disp) begin n_pass++; end
    else $error("FAIL %s display got %h expected %h", tag, display, exp_disp);
    n_checks++;
    assert (stable === m_stable) begin n_pass++; end
    else $error("FAIL %s stable got %b expected %b", tag, stable, m_stable);
    n_checks++;
    assert (one_hz === exp_hz) begin n_pass++; end
    else $error("FAIL %s one_hz got %b expected %b", tag, one_hz, exp_hz);
  endtask

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) begin n_pass++; end
    else $error("FAIL %s got %h expected %h", tag, got, exp);
  endtask

  bit gaps = 0;

  task automatic send_byte(input bit h, input bit s);
    if (gaps) repeat ($urandom_range(0, 2)) step(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);
    step(1, h, s, 0);
  endtask

  // Row of period p: p-2 bytes with hsync high, then two low. The frame ends
  // on the last row's final byte, so every row period is p and rowlen is p-1.
  task automatic send_frame();
    for (int r = 0; r < fr_q.size(); r++) begin
      for (int b = 0; b < fr_q[r] - 2; b++) send_byte(1, 1);
      send_byte(0, 1);
      send_byte(0, (r == fr_q.size() - 1) ? 1'b0 : 1'b1);
    end
  endtask

  task automatic wait_hz(input string tag);
    int n;
    n = 0;
    while (!exp_hz && n < 3 * REF) begin step(0, 0, 0, 0); n++; end
    n_checks++;
    assert (one_hz === 1'b1 && exp_hz) begin n_pass++; end
    else $error("FAIL %s one_hz got %b expected 1 after %0d cycles", tag, one_hz, n);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired before the summary");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset(0);
    repeat (3) @(posedge clk);
    #1 check("reset");
    rst_n = 1'b1;

    // Directed: 3 rows of rowlen 10 after a priming frame.
    mode = 3'd0;
    fr_q = '{11, 11, 11}; send_frame();
    send_frame();
    step(0, 0, 0, 0); check("geom_model");
    check_val("geom_mode0", display, 32'h0003_000A);
    mode = 3'd1; step(0, 0, 0, 0); check("geom_fbytes");

    // Unequal rows: min/max, no stability.
    mode = 3'd3;
    fr_q = '{11, 13, 10}; send_frame();
    step(0, 0, 0, 0); check("minmax_model");
    check_val("minmax_mode3", display, 32'h000C_0009);
    check_val("minmax_stable", {31'b0, stable}, 32'h0);

    // Five identical frames bring stability, one odd row drops it.
    mode = 3'd5;
    fr_q = '{11, 11, 11, 11};
    for (int k = 1; k <= 5; k++) begin
      send_frame();
      step(0, 0, 0, 0); check("stab_frame");
    end
    check_val("stab_mode5", display, 32'h0004_0001);
    check_val("stab_flag", {31'b0, stable}, 32'h1);
    fr_q = '{11, 12, 11, 11}; send_frame();
    step(0, 0, 0, 0); check("stab_break");
    check_val("stab_drop", {31'b0, stable}, 32'h0);

    // fps window with a frame_end coincident with one_hz.
    mode = 3'd2;
    wait_hz("fps_sync");
    step(0, 0, 0, 0);
    fr_q = '{5, 5};
    repeat (3) send_frame();
    repeat (3) step(1, 1, 1, 0);
    wait_hz("fps_edge");
    step(1, 0, 0, 0);
    step(0, 0, 0, 0); check("fps_model");
    check_val("fps_three", {16'h0, display[31:16]}, 32'd3);
    wait_hz("fps_next");
    step(0, 0, 0, 0);
    step(0, 0, 0, 0); check("fps_next_model");
    check_val("fps_one", {16'h0, display[31:16]}, 32'd1);
    mode = 3'd4; step(0, 0, 0, 0); check("bps_model");

    // Row counter saturation.
    mode = 3'd0;
    repeat (70000) step(1, 1, 1, 0);
    step(1, 0, 1, 0);
    step(0, 0, 0, 0); check("sat_model");
    check_val("sat_rowlen", {16'h0, display[15:0]}, 32'h0000_FFFF);

    // Randomized frames with idle gaps, every display mode checked per frame.
    gaps = 1;
    for (int f = 0; f < 6; f++) begin
      fr_q.delete();
      repeat ($urandom_range(1, 4)) fr_q.push_back($urandom_range(4, 14));
      send_frame();
      for (int md = 0; md < 8; md++) begin
        mode = 3'(md);
        step(0, 0, 0, 0); check("rand_frame");
      end
    end
    gaps = 0;

    // Asynchronous reset in the middle of a row.
    repeat (5) step(1, 1, 1, 0);
    #2 rst_n = 1'b0;
    model_reset(0);
    #1 check("rst_mid");
    @(posedge clk);
    #1 rst_n = 1'b1;
    mode = 3'd0;
    fr_q = '{11, 11}; send_frame();
    step(0, 0, 0, 0); check("rst_after_frame");

    // Clear wins over a simultaneous frame_end.
    mode = 3'd1;
    repeat (4) step(1, 1, 1, 0);
    step(1, 0, 0, 1); check("clear_cycle");
    check_val("clear_disp", display, 32'h0);
    for (int md = 0; md < 6; md++) begin
      mode = 3'(md);
      step(0, 0, 0, 0); check("clear_mode");
      check_val("clear_zero", display, 32'h0);
    end
    wait_hz("clear_timebase");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
